// File: rtl/alu_result_display.sv
// Consumer end of the ALU result path: latches a result over valid/ready and
// scans it onto a two-digit multiplexed hex 7-segment display (dp = carry).
module alu_result_display #(
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned HOLD_CYCLES  = 4096,
    parameter bit          COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [7:0] res_data,
    input  logic       res_cout,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] dig_en
);

    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    // Display-off levels double as the polarity masks for lit values.
    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = COMMON_ANODE;
    localparam logic [1:0] EN_OFF  = COMMON_ANODE ? 2'b11 : 2'b00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_ready;
    logic [7:0]           r_data;
    logic                 r_cout;
    logic [PRESC_W-1:0]   r_presc;
    logic                 r_digit;
    logic [HOLD_W-1:0]    r_hold;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [1:0]           r_dig_en;

    logic                 w_accept;
    logic [3:0]           w_nibble;
    logic [6:0]           w_hex;
    logic [6:0]           w_seg_nx;
    logic                 w_dp_nx;
    logic [1:0]           w_en_nx;

    assign w_accept = res_valid & r_ready & ~clr;
    assign w_nibble = r_digit ? r_data[7:4] : r_data[3:0];

    // Active-high hex glyphs, segment order {g,f,e,d,c,b,a}.
    always_comb begin
        w_hex = 7'h00;
        case (w_nibble)
            4'h0: w_hex = 7'h3F;
            4'h1: w_hex = 7'h06;
            4'h2: w_hex = 7'h5B;
            4'h3: w_hex = 7'h4F;
            4'h4: w_hex = 7'h66;
            4'h5: w_hex = 7'h6D;
            4'h6: w_hex = 7'h7D;
            4'h7: w_hex = 7'h07;
            4'h8: w_hex = 7'h7F;
            4'h9: w_hex = 7'h6F;
            4'hA: w_hex = 7'h77;
            4'hB: w_hex = 7'h7C;
            4'hC: w_hex = 7'h39;
            4'hD: w_hex = 7'h5E;
            4'hE: w_hex = 7'h79;
            4'hF: w_hex = 7'h71;
            default: w_hex = 7'h00;
        endcase
    end

    // Next display drive from the current digit and latched value.
    always_comb begin
        w_seg_nx = SEG_OFF;
        w_dp_nx  = DP_OFF;
        w_en_nx  = EN_OFF;
        if (r_state == ST_SHOW) begin
            w_seg_nx = w_hex ^ SEG_OFF;
            w_dp_nx  = (r_digit & r_cout) ^ DP_OFF;
            w_en_nx  = (r_digit ? 2'b10 : 2'b01) ^ EN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BLANK;
            r_ready  <= 1'b1;
            r_data   <= 8'h00;
            r_cout   <= 1'b0;
            r_presc  <= '0;
            r_digit  <= 1'b0;
            r_hold   <= '0;
            r_seg    <= SEG_OFF;
            r_dp     <= DP_OFF;
            r_dig_en <= EN_OFF;
        end else if (clr) begin
            r_state  <= ST_BLANK;
            r_ready  <= 1'b1;
            r_data   <= 8'h00;
            r_cout   <= 1'b0;
            r_presc  <= '0;
            r_digit  <= 1'b0;
            r_hold   <= '0;
            r_seg    <= SEG_OFF;
            r_dp     <= DP_OFF;
            r_dig_en <= EN_OFF;
        end else begin
            r_seg    <= w_seg_nx;
            r_dp     <= w_dp_nx;
            r_dig_en <= w_en_nx;

            // Hold window keeps each accepted result on display for a while.
            if (w_accept) begin
                r_data  <= res_data;
                r_cout  <= res_cout;
                r_state <= ST_SHOW;
                r_hold  <= HOLD_INIT;
                r_ready <= 1'b0;
            end else if (!r_ready) begin
                if (r_hold == '0) begin
                    r_ready <= 1'b1;
                end else begin
                    r_hold <= r_hold - HOLD_W'(1);
                end
            end

            // Scan phase free-runs in SHOW; a new accept does not restart it.
            if (r_state == ST_SHOW) begin
                if (r_presc == PRESC_MAX) begin
                    r_presc <= '0;
                    r_digit <= ~r_digit;
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end else begin
                r_presc <= '0;
                r_digit <= 1'b0;
            end
        end
    end

    assign res_ready = r_ready;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign dig_en    = r_dig_en;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: timed scan/hold trace, vector table,
// clear and reset corner cases, common-anode polarity, full 0x00..0xFF sweep.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, valid, cout;
    logic [7:0] data;
    logic       sw_clr, sw_valid, sw_cout;
    logic [7:0] sw_data;

    logic       m_ready, ca_ready, sw_ready;
    logic [6:0] m_seg, ca_seg, sw_seg;
    logic       m_dp, ca_dp, sw_dp;
    logic [1:0] m_en, ca_en, sw_en;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        logic       cout;
        logic [6:0] seg_lo;
        logic [6:0] seg_hi;
        logic       dp_hi;
    } vec_t;

    typedef struct {
        logic [1:0] en;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } step_t;

    vec_t  vecs [8];
    step_t hs   [18];

    always #5 clk = ~clk;

    alu_result_display #(.SCAN_DIV(4), .HOLD_CYCLES(8), .COMMON_ANODE(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(clr), .res_valid(valid), .res_ready(m_ready),
        .res_data(data), .res_cout(cout), .seg(m_seg), .dp(m_dp), .dig_en(m_en)
    );

    alu_result_display #(.SCAN_DIV(4), .HOLD_CYCLES(8), .COMMON_ANODE(1'b1)) u_ca (
        .clk(clk), .rst_n(rst_n), .clr(clr), .res_valid(valid), .res_ready(ca_ready),
        .res_data(data), .res_cout(cout), .seg(ca_seg), .dp(ca_dp), .dig_en(ca_en)
    );

    alu_result_display #(.SCAN_DIV(2), .HOLD_CYCLES(1), .COMMON_ANODE(1'b0)) u_sw (
        .clk(clk), .rst_n(rst_n), .clr(sw_clr), .res_valid(sw_valid), .res_ready(sw_ready),
        .res_data(sw_data), .res_cout(sw_cout), .seg(sw_seg), .dp(sw_dp), .dig_en(sw_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Digit enables must be one-hot or all off on every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("main_en_not_both", 32'(m_en == 2'b11), 0);
            chk("ca_en_not_both", 32'(ca_en == 2'b00), 0);
            chk("sw_en_not_both", 32'(sw_en == 2'b11), 0);
        end
    end

    // Offer one vector to u_main, check the hold length and both digit glyphs.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        bit seen_lo, seen_hi;
        @(negedge clk);
        data = v.data; cout = v.cout; valid = 1'b1;
        n = 0;
        while (!m_ready && n < 50) begin @(negedge clk); n++; end
        chk($sformatf("vec%0d_ready_before", idx), 32'(m_ready), 1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (!m_ready && n < 50) begin n++; @(negedge clk); end
        chk($sformatf("vec%0d_hold_len", idx), 32'(n), 8);
        seen_lo = 1'b0; seen_hi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_en == 2'b01) begin
                seen_lo = 1'b1;
                chk($sformatf("vec%0d_seg_lo", idx), 32'(m_seg), 32'(v.seg_lo));
                chk($sformatf("vec%0d_dp_lo", idx), 32'(m_dp), 0);
            end else if (m_en == 2'b10) begin
                seen_hi = 1'b1;
                chk($sformatf("vec%0d_seg_hi", idx), 32'(m_seg), 32'(v.seg_hi));
                chk($sformatf("vec%0d_dp_hi", idx), 32'(m_dp), 32'(v.dp_hi));
            end else begin
                chk($sformatf("vec%0d_lit", idx), 32'(m_en), 1);
            end
        end
        chk($sformatf("vec%0d_both_digits", idx), 32'({seen_lo, seen_hi}), 3);
    endtask

    task automatic run_sweep();
        logic [7:0] b;
        int n;
        bit seen_lo, seen_hi;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            @(negedge clk);
            sw_data = b; sw_cout = b[0]; sw_valid = 1'b1;
            n = 0;
            while (!sw_ready && n < 20) begin @(negedge clk); n++; end
            chk("sw_ready_before", 32'(sw_ready), 1);
            @(posedge clk);
            @(negedge clk);
            sw_valid = 1'b0;
            seen_lo = 1'b0; seen_hi = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (sw_en == 2'b01) begin
                    seen_lo = 1'b1;
                    chk($sformatf("sw_%02h_seg_lo", b), 32'(sw_seg), 32'(hex7(b[3:0])));
                    chk($sformatf("sw_%02h_dp_lo", b), 32'(sw_dp), 0);
                end else if (sw_en == 2'b10) begin
                    seen_hi = 1'b1;
                    chk($sformatf("sw_%02h_seg_hi", b), 32'(sw_seg), 32'(hex7(b[7:4])));
                    chk($sformatf("sw_%02h_dp_hi", b), 32'(sw_dp), 32'(b[0]));
                end else begin
                    chk($sformatf("sw_%02h_lit", b), 32'(sw_en), 1);
                end
            end
            chk($sformatf("sw_%02h_both_digits", b), 32'({seen_lo, seen_hi}), 3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h80, 1'b0, 7'h3F, 7'h7F, 1'b0};
        vecs[1] = '{8'h80, 1'b1, 7'h3F, 7'h7F, 1'b1};
        vecs[2] = '{8'h12, 1'b0, 7'h5B, 7'h06, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 7'h6D, 7'h77, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 7'h71, 7'h71, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 7'h39, 7'h4F, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 7'h3F, 7'h3F, 1'b1};
        vecs[7] = '{8'h7E, 1'b1, 7'h79, 7'h07, 1'b1};

        // A5 accepted from BLANK at edge A; 3C held during the hold window and
        // taken at A+9. Entry k is sampled on the falling edge after A+k.
        hs[0]  = '{2'b00, 7'h00, 1'b0, 1'b0};
        for (int k = 1; k <= 4; k++)  hs[k] = '{2'b01, 7'h6D, 1'b0, 1'b0};
        for (int k = 5; k <= 7; k++)  hs[k] = '{2'b10, 7'h77, 1'b1, 1'b0};
        hs[8]  = '{2'b10, 7'h77, 1'b1, 1'b1};
        hs[9]  = '{2'b01, 7'h6D, 1'b0, 1'b0};
        for (int k = 10; k <= 12; k++) hs[k] = '{2'b01, 7'h39, 1'b0, 1'b0};
        for (int k = 13; k <= 16; k++) hs[k] = '{2'b10, 7'h4F, 1'b0, 1'b0};
        hs[17] = '{2'b01, 7'h39, 1'b0, 1'b1};

        rst_n = 1'b0; clr = 1'b0; valid = 1'b0; data = 8'h00; cout = 1'b0;
        sw_clr = 1'b0; sw_valid = 1'b0; sw_data = 8'h00; sw_cout = 1'b0;

        @(posedge clk);
        #1;
        chk("rst_seg", 32'(m_seg), 0);
        chk("rst_dp", 32'(m_dp), 0);
        chk("rst_en", 32'(m_en), 0);
        chk("rst_ready", 32'(m_ready), 1);
        chk("rst_ca_seg", 32'(ca_seg), 32'h7F);
        chk("rst_ca_dp", 32'(ca_dp), 1);
        chk("rst_ca_en", 32'(ca_en), 3);
        chk("rst_sw_ready", 32'(sw_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Timed trace: hold length, scan cadence, blocked offer, unrestarted phase.
        @(negedge clk);
        data = 8'hA5; cout = 1'b1; valid = 1'b1;
        chk("hs_ready_before", 32'(m_ready), 1);
        @(posedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("hs%0d_en", k), 32'(m_en), 32'(hs[k].en));
            chk($sformatf("hs%0d_seg", k), 32'(m_seg), 32'(hs[k].seg));
            chk($sformatf("hs%0d_dp", k), 32'(m_dp), 32'(hs[k].dp));
            chk($sformatf("hs%0d_ready", k), 32'(m_ready), 32'(hs[k].rdy));
            if (k == 1) begin
                chk("ca_lo_seg", 32'(ca_seg), 32'h12);
                chk("ca_lo_en", 32'(ca_en), 2);
                chk("ca_lo_dp", 32'(ca_dp), 1);
            end
            if (k == 5) begin
                chk("ca_hi_seg", 32'(ca_seg), 32'h08);
                chk("ca_hi_en", 32'(ca_en), 1);
                chk("ca_hi_dp", 32'(ca_dp), 0);
            end
            if (k == 0) begin data = 8'h3C; cout = 1'b0; valid = 1'b1; end
            if (k == 9) valid = 1'b0;
        end

        // Asynchronous reset pulse while scanning.
        #1 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(m_seg), 0);
        chk("arst_dp", 32'(m_dp), 0);
        chk("arst_en", 32'(m_en), 0);
        chk("arst_ready", 32'(m_ready), 1);
        chk("arst_ca_seg", 32'(ca_seg), 32'h7F);
        chk("arst_ca_dp", 32'(ca_dp), 1);
        chk("arst_ca_en", 32'(ca_en), 3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_blank_after", 32'(m_en), 0);
        chk("arst_seg_after", 32'(m_seg), 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Clear beats a simultaneous offer.
        @(negedge clk);
        clr = 1'b1; valid = 1'b1; data = 8'hFF; cout = 1'b0;
        @(negedge clk);
        clr = 1'b0; valid = 1'b0;
        chk("clr_seg", 32'(m_seg), 0);
        chk("clr_dp", 32'(m_dp), 0);
        chk("clr_en", 32'(m_en), 0);
        chk("clr_ready", 32'(m_ready), 1);
        @(negedge clk);
        chk("clr_no_accept_en", 32'(m_en), 0);
        chk("clr_no_accept_ready", 32'(m_ready), 1);
        run_vec(8, vecs[4]);

        run_sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
